// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: execute -> memory pipeline register.
// A two-entry skid buffer with a valid/ready handshake. The main entry drives
// the memory stage; the skid entry parks one extra instruction while the
// memory stage is stalled. Output order always matches acceptance order.
// A flush drops every held entry; a reset does the same and also clears
// the payload registers.
// Optional feature: define EX_MEM_PERF_CNT_EN to build the saturating
// stall/flush event counters. When it is not defined, both counter ports
// read 0 and no counter flops exist.
module ex_mem_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int RD_WIDTH    = 5,
  parameter int LSUOP_WIDTH = 3,
  parameter int WBSEL_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  // Execute side
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_opr_res,
  input  logic [DATA_WIDTH-1:0]  in_opr_b,
  input  logic [RD_WIDTH-1:0]    in_rd,
  input  logic [DATA_WIDTH-1:0]  in_pc4,
  input  logic [LSUOP_WIDTH-1:0] in_lsuop,
  input  logic                   in_dm_en,
  input  logic                   in_rf_en,
  input  logic [WBSEL_WIDTH-1:0] in_wb_sel,
  // Memory side
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_opr_res,
  output logic [DATA_WIDTH-1:0]  out_opr_b,
  output logic [RD_WIDTH-1:0]    out_rd,
  output logic [DATA_WIDTH-1:0]  out_pc4,
  output logic [LSUOP_WIDTH-1:0] out_lsuop,
  output logic                   out_dm_en,
  output logic                   out_rf_en,
  output logic [WBSEL_WIDTH-1:0] out_wb_sel,
  // Performance counters
  output logic [31:0]            stall_cnt,
  output logic [31:0]            flush_cnt
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  opr_res;
    logic [DATA_WIDTH-1:0]  opr_b;
    logic [RD_WIDTH-1:0]    rd;
    logic [DATA_WIDTH-1:0]  pc4;
    logic [LSUOP_WIDTH-1:0] lsuop;
    logic                   dm_en;
    logic                   rf_en;
    logic [WBSEL_WIDTH-1:0] wb_sel;
  } payload_t;

  payload_t in_pl;
  payload_t main_q;
  payload_t skid_q;
  logic     main_v;
  logic     skid_v;
  logic     acc;
  logic     con;

  assign in_pl = '{opr_res: in_opr_res, opr_b: in_opr_b, rd: in_rd,
                   pc4: in_pc4, lsuop: in_lsuop, dm_en: in_dm_en,
                   rf_en: in_rf_en, wb_sel: in_wb_sel};

  // The skid slot is the only thing that can refuse input. Flush also blocks
  // capture so that nothing arriving in the flush cycle survives it.
  assign in_ready = !skid_v && !flush;
  assign acc      = in_valid && in_ready;
  assign con      = main_v && out_ready;

  // Entry state and payload: load, park, promote or drop entries.
  // NOTE: all state is updated with non-blocking assignments so that every
  // branch reads the pre-edge value of main_q/skid_q (promoting skid to main
  // in the same edge as a skid load would otherwise race).
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      // NOTE: payload registers are cleared on reset too, so out_* read 0
      // straight out of reset rather than holding stale or unknown values.
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      // Payload keeps its last value; only the valid bits matter.
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v) begin
      // Empty: skid is never occupied without main.
      if (acc) begin
        main_q <= in_pl;
        main_v <= 1'b1;
      end
    end else if (!skid_v) begin
      // Main only.
      if (acc && con) begin
        main_q <= in_pl;
      end else if (acc) begin
        skid_q <= in_pl;
        skid_v <= 1'b1;
      end else if (con) begin
        main_v <= 1'b0;
      end
    end else begin
      // Full: input is blocked, a consume promotes the older skid entry.
      if (con) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end
    end
  end

  assign out_valid   = main_v;
  assign out_opr_res = main_q.opr_res;
  assign out_opr_b   = main_q.opr_b;
  assign out_rd      = main_q.rd;
  assign out_pc4     = main_q.pc4;
  assign out_lsuop   = main_q.lsuop;
  assign out_wb_sel  = main_q.wb_sel;
  // Write enables are qualified so a bubble can never write memory or the RF.
  assign out_dm_en   = main_q.dm_en && main_v;
  assign out_rf_en   = main_q.rf_en && main_v;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Saturating event counters: memory-side stall cycles and flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (main_v && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (flush && (flush_q != 32'hFFFF_FFFF)) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Testbench for ex_mem_pipe: a directed vector table, hand-written sequences
// for streaming and the counters, then randomized traffic checked against a
// FIFO-queue reference model.
module tb_ex_mem_pipe;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int LW = 3;
  localparam int WW = 2;

`ifdef EX_MEM_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_opr_res;
  logic [DW-1:0] in_opr_b;
  logic [RW-1:0] in_rd;
  logic [DW-1:0] in_pc4;
  logic [LW-1:0] in_lsuop;
  logic          in_dm_en;
  logic          in_rf_en;
  logic [WW-1:0] in_wb_sel;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_opr_res;
  logic [DW-1:0] out_opr_b;
  logic [RW-1:0] out_rd;
  logic [DW-1:0] out_pc4;
  logic [LW-1:0] out_lsuop;
  logic          out_dm_en;
  logic          out_rf_en;
  logic [WW-1:0] out_wb_sel;
  logic [31:0]   stall_cnt;
  logic [31:0]   flush_cnt;

  always #5 clk = ~clk;

  ex_mem_pipe #(
    .DATA_WIDTH(DW), .RD_WIDTH(RW), .LSUOP_WIDTH(LW), .WBSEL_WIDTH(WW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opr_res(in_opr_res), .in_opr_b(in_opr_b), .in_rd(in_rd),
    .in_pc4(in_pc4), .in_lsuop(in_lsuop), .in_dm_en(in_dm_en),
    .in_rf_en(in_rf_en), .in_wb_sel(in_wb_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opr_res(out_opr_res), .out_opr_b(out_opr_b), .out_rd(out_rd),
    .out_pc4(out_pc4), .out_lsuop(out_lsuop), .out_dm_en(out_dm_en),
    .out_rf_en(out_rf_en), .out_wb_sel(out_wb_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Directed vectors: inputs for one cycle, in_ready expected in that cycle,
  // and outputs expected after its rising edge.
  typedef struct {
    logic          rst;
    logic          flush;
    logic          iv;
    logic          ordy;
    logic [DW-1:0] res;
    logic [RW-1:0] rd;
    logic          dm;
    logic          rf;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_res;
    logic [RW-1:0] e_rd;
    logic          e_dm;
  } vec_t;

  vec_t vecs[16];

  // Reference model: the pipe is an in-order queue of at most two entries.
  typedef struct {
    logic [DW-1:0] res;
    logic [DW-1:0] b;
    logic [RW-1:0] rd;
    logic [DW-1:0] pc4;
    logic [LW-1:0] lsuop;
    logic          dm;
    logic          rf;
    logic [WW-1:0] wb;
  } item_t;

  item_t       model_q[$];
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [DW-1:0] res, input logic [RW-1:0] rd,
                       input logic dm, input logic rf);
    rst        = r;
    flush      = f;
    in_valid   = iv;
    out_ready  = ordy;
    in_opr_res = res;
    in_opr_b   = '0;
    in_rd      = rd;
    in_pc4     = '0;
    in_lsuop   = '0;
    in_dm_en   = dm;
    in_rf_en   = rf;
    in_wb_sel  = '0;
  endtask

  initial begin
    item_t it;
    logic  exp_ir;
    logic  acc;
    logic  con;

    // rst flush iv ordy res rd dm rf | e_ir e_ov e_res e_rd e_dm
    // basic
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 5'd5,  1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 5'd5, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,   5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   5'd0, 1'b0};
    // backpressure skid: A, B accepted, C held, then drained in order
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h10,  5'd1,  1'b0, 1'b1, 1'b1, 1'b1, 32'h10,  5'd1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h20,  5'd2,  1'b0, 1'b1, 1'b1, 1'b1, 32'h10,  5'd1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h30,  5'd3,  1'b0, 1'b1, 1'b0, 1'b1, 32'h10,  5'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h30,  5'd3,  1'b0, 1'b1, 1'b0, 1'b1, 32'h20,  5'd2, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h30,  5'd3,  1'b0, 1'b1, 1'b1, 1'b1, 32'h30,  5'd3, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,   5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   5'd0, 1'b0};
    // flush with both entries holding stores
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h40,  5'd4,  1'b1, 1'b0, 1'b1, 1'b1, 32'h40,  5'd4, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h50,  5'd6,  1'b1, 1'b0, 1'b1, 1'b1, 32'h40,  5'd4, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h60,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   5'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,   5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   5'd0, 1'b0};
    // reset mid-operation with flush and in_valid
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h70,  5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 32'h70,  5'd8, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h80,  5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 32'h70,  5'd8, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h90,  5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   5'd0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   5'd0, 1'b0};

    // Reset for two cycles and check the reset state.
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset out_valid",   {63'd0, out_valid}, 64'd0);
    check("reset in_ready",    {63'd0, in_ready},  64'd1);
    check("reset out_opr_res", {32'd0, out_opr_res}, 64'd0);
    check("reset out_opr_b",   {32'd0, out_opr_b},   64'd0);
    check("reset out_rd",      {59'd0, out_rd},      64'd0);
    check("reset out_pc4",     {32'd0, out_pc4},     64'd0);
    check("reset out_lsuop",   {61'd0, out_lsuop},   64'd0);
    check("reset out_wb_sel",  {62'd0, out_wb_sel},  64'd0);
    check("reset out_dm_en",   {63'd0, out_dm_en},   64'd0);
    check("reset out_rf_en",   {63'd0, out_rf_en},   64'd0);
    check("reset stall_cnt",   {32'd0, stall_cnt},   64'd0);
    check("reset flush_cnt",   {32'd0, flush_cnt},   64'd0);

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].ordy,
            vecs[i].res, vecs[i].rd, vecs[i].dm, vecs[i].rf);
      #1;
      check($sformatf("vec%0d in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].e_ir});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
      check($sformatf("vec%0d out_dm_en", i), {63'd0, out_dm_en}, {63'd0, vecs[i].e_dm});
      if (vecs[i].e_ov) begin
        check($sformatf("vec%0d out_opr_res", i), {32'd0, out_opr_res}, {32'd0, vecs[i].e_res});
        check($sformatf("vec%0d out_rd", i), {59'd0, out_rd}, {59'd0, vecs[i].e_rd});
      end
    end
    check("post-reset stall_cnt", {32'd0, stall_cnt}, 64'd0);
    check("post-reset flush_cnt", {32'd0, flush_cnt}, 64'd0);

    // Streaming: one instruction per cycle, each visible the cycle after.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 1'b1, DW'(i), RW'(i), 1'b0, 1'b1);
      #1;
      check($sformatf("stream%0d in_ready", i), {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      check($sformatf("stream%0d out_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("stream%0d out_opr_res", i), {32'd0, out_opr_res}, 64'(i));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("stream drained out_valid", {63'd0, out_valid}, 64'd0);

    // Performance counters: 5 stall cycles, then 2 flush cycles.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hAA, 5'd1, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("perf stall_cnt", {32'd0, stall_cnt}, PERF ? 64'd5 : 64'd0);
    check("perf flush_cnt", {32'd0, flush_cnt}, PERF ? 64'd2 : 64'd0);
    check("perf out_valid", {63'd0, out_valid}, 64'd0);

    // Randomized traffic against the queue model.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    model_q.delete();
    m_stall = '0;
    m_flush = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 19) == 0);
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 6);
      in_opr_res = $urandom;
      in_opr_b   = $urandom;
      in_rd      = RW'($urandom);
      in_pc4     = $urandom;
      in_lsuop   = LW'($urandom);
      in_dm_en   = 1'($urandom);
      in_rf_en   = 1'($urandom);
      in_wb_sel  = WW'($urandom);
      #1;
      exp_ir = (model_q.size() < 2) && !flush;
      check($sformatf("rand%0d in_ready", c), {63'd0, in_ready}, {63'd0, exp_ir});
      it = '{in_opr_res, in_opr_b, in_rd, in_pc4, in_lsuop, in_dm_en, in_rf_en, in_wb_sel};
      if (rst) begin
        model_q.delete();
        m_stall = '0;
        m_flush = '0;
      end else begin
        if (model_q.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (flush && m_flush != 32'hFFFF_FFFF) m_flush++;
        if (flush) begin
          model_q.delete();
        end else begin
          con = (model_q.size() > 0) && out_ready;
          acc = in_valid && (model_q.size() < 2);
          if (con) void'(model_q.pop_front());
          if (acc) model_q.push_back(it);
        end
      end
      @(posedge clk);
      #1;
      check($sformatf("rand%0d out_valid", c), {63'd0, out_valid}, {63'd0, model_q.size() > 0});
      if (model_q.size() > 0) begin
        check($sformatf("rand%0d out_opr_res", c), {32'd0, out_opr_res}, {32'd0, model_q[0].res});
        check($sformatf("rand%0d out_opr_b", c),   {32'd0, out_opr_b},   {32'd0, model_q[0].b});
        check($sformatf("rand%0d out_rd", c),      {59'd0, out_rd},      {59'd0, model_q[0].rd});
        check($sformatf("rand%0d out_pc4", c),     {32'd0, out_pc4},     {32'd0, model_q[0].pc4});
        check($sformatf("rand%0d out_lsuop", c),   {61'd0, out_lsuop},   {61'd0, model_q[0].lsuop});
        check($sformatf("rand%0d out_wb_sel", c),  {62'd0, out_wb_sel},  {62'd0, model_q[0].wb});
        check($sformatf("rand%0d out_dm_en", c),   {63'd0, out_dm_en},   {63'd0, model_q[0].dm});
        check($sformatf("rand%0d out_rf_en", c),   {63'd0, out_rf_en},   {63'd0, model_q[0].rf});
      end else begin
        check($sformatf("rand%0d bubble dm_en", c), {63'd0, out_dm_en}, 64'd0);
        check($sformatf("rand%0d bubble rf_en", c), {63'd0, out_rf_en}, 64'd0);
      end
      check($sformatf("rand%0d stall_cnt", c), {32'd0, stall_cnt}, PERF ? {32'd0, m_stall} : 64'd0);
      check($sformatf("rand%0d flush_cnt", c), {32'd0, flush_cnt}, PERF ? {32'd0, m_flush} : 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Pipeline register between the execute stage and the memory stage.
- Captures execute results and control (ALU result, store data, rd, pc4, lsuop, dm_en, rf_en, wb_sel) and presents them to the memory stage.
- Implemented as a two-entry skid buffer with a valid/ready handshake, so backpressure from the memory side never drops or duplicates an instruction.
- Supports a flush from hazard/branch control.

Parameters:
- DATA_WIDTH, 32: width of opr_res, opr_b and pc4.
- RD_WIDTH, 5: destination register index width.
- LSUOP_WIDTH, 3: load/store operation encoding width.
- WBSEL_WIDTH, 2: writeback select width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard all held entries; block input this cycle.
- in_valid  in  1  execute presents an instruction.
- in_ready  out  1  pipe can accept.
- in_opr_res  in  DATA_WIDTH  ALU result / memory address.
- in_opr_b  in  DATA_WIDTH  store data.
- in_rd  in  RD_WIDTH  destination register.
- in_pc4  in  DATA_WIDTH  PC+4.
- in_lsuop  in  LSUOP_WIDTH  load/store type.
- in_dm_en  in  1  data-memory write enable.
- in_rf_en  in  1  register-file write enable.
- in_wb_sel  in  WBSEL_WIDTH  writeback source.
- out_valid  out  1  memory stage has a valid instruction.
- out_ready  in  1  memory stage consumes.
- out_opr_res, out_opr_b, out_rd, out_pc4, out_lsuop, out_dm_en, out_rf_en, out_wb_sel  out  widths as inputs  registered payload.
- stall_cnt  out  32  backpressure cycle count (optional feature).
- flush_cnt  out  32  flush event count (optional feature).

Behaviour:
- Storage:
  - Main entry (main_v + payload) drives out_*.
  - Skid entry (skid_v + payload) holds one extra instruction.
- Reset: main_v=0, skid_v=0, all payload registers 0. Consequently out_valid=0, in_ready=1, all out_* = 0, counters 0.
- Handshakes:
  - in_ready = !skid_v && !flush (combinational from registered state and flush).
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - out_valid = main_v.
- Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N and stays until consumed.
- Transitions, non-flush (acc = input accepted, con = output consumed):
  - Empty (main_v=0): acc loads main.
  - Main only: acc && con loads main from input. acc && !con loads skid from input. con && !acc clears main_v.
  - Full (main_v=1, skid_v=1): in_ready=0. con moves skid to main and clears skid_v. No acceptance is possible.
- Ordering: output order always equals acceptance order. Skid data never bypasses main.
- Flush:
  - Flush clears main_v and skid_v on the next edge.
  - in_ready=0 during flush, so no capture in the flush cycle.
  - A consume in the same cycle is still a legal handshake; the entry is removed either way.
- Side-effect gating:
  - out_dm_en = main_dm_en && main_v.
  - out_rf_en = main_rf_en && main_v.
  - No memory or register write is ever issued from a bubble.
- Payload: other out_* fields keep their last value when out_valid=0. Only valid-qualified use is defined.
- Reset mid-operation: rst overrides flush and all handshakes. Every held entry is dropped on the next edge.
- No combinational path from in_* payload to out_*.
- out_ready may depend combinationally on out_*.

Optional Feature:
- Macro: EX_MEM_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid && !out_ready.
  - flush_cnt increments each cycle with flush=1.
  - Both are 32-bit, saturating at 0xFFFF_FFFF, cleared by rst.
- Not defined: stall_cnt and flush_cnt are tied to 0 and no counter flops are synthesised. Ports remain present.

Test Plan:
- Reset/basic: assert rst 2 cycles → out_valid=0, in_ready=1, outputs 0. Then present opr_res=0x100, rd=5, rf_en=1 with out_ready=1 → next cycle out_valid=1, out_opr_res=0x100, out_rd=5.
- Backpressure skid: out_ready=0, send A(opr_res=0x10) then B(0x20) in consecutive cycles → both accepted; in_ready=0 after B; C is held off. Raise out_ready → outputs A, then B, then C in order with no loss or duplication.
- Streaming: in_valid=1, out_ready=1 for 8 cycles with opr_res=0..7 → out_opr_res 0..7 on consecutive cycles; in_ready stays 1.
- Flush full: fill both entries (stores, dm_en=1), assert flush 1 cycle with in_valid=1 → in_ready=0 that cycle. Next cycle out_valid=0 and out_dm_en=0; the flush-cycle input is not captured.
- Reset mid-operation: both entries full, assert rst together with flush and in_valid → next cycle out_valid=0, in_ready=1, counters 0.
- Perf counters (EX_MEM_PERF_CNT_EN defined): hold out_valid=1, out_ready=0 for 5 cycles, then flush 2 cycles → stall_cnt=5, flush_cnt=2. Macro undefined → both read 0.
